// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction-time controller.
//   state_t      : controller FSM states
//   LFSR_SEED    : LFSR reset value
//   LFSR_TAPS    : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   FOUL_CODE    : digit code shown on every display while in FOUL
//   lfsr_next()  : one LFSR step
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_MEASURE = 3'd2,
    S_DONE    = 3'd3,
    S_FOUL    = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  FOUL_CODE = 4'hF;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_bcd_counter4.sv
// bcd_counter4: 4-digit BCD up-counter that saturates at 9999.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0000 (wins over inc)
//   inc        : add one (ignored once at 9999)
//   bcd        : {d3,d2,d1,d0}, d0 least significant
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] bcd
);

  logic [15:0] r_bcd;
  logic [15:0] w_inc_val;
  logic        w_carry;
  logic        w_sat;

  assign w_sat = (r_bcd == 16'h9999);

  // Ripple the +1 through the digits: a digit at 9 rolls to 0 and passes
  // the carry on, the first digit below 9 absorbs it.
  always_comb begin
    w_carry   = 1'b1;
    w_inc_val = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_inc_val[4*i +: 4] = 4'd0;
        end else begin
          w_inc_val[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_bcd <= 16'h0000;
    else if (clr)            r_bcd <= 16'h0000;
    else if (inc && !w_sat)  r_bcd <= w_inc_val;
  end

  assign bcd = r_bcd;

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time game controller.
//   iCLK, iRST_n      : clock, async active-low reset
//   iSTART            : one-cycle start request (synchronized)
//   iRESP             : response button level (synchronized, debounced)
//   oLED              : stimulus lamp, high while measuring
//   oDIGIT0..oDIGIT3  : BCD / code digits for the hex displays, 0 = LSD
//   oFOUL             : high after a premature response
//   oBUSY             : high while waiting or measuring
// A start loads a pseudo-random delay (MIN_WAIT_MS + lfsr[10:0] ms); when it
// expires the lamp lights and the ms count runs until the button is pressed.
// All outputs are registered from the current state, so they trail the
// state register by one cycle.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MIN_WAIT_MS = 1000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iSTART,
  input  logic       iRESP,
  output logic       oLED,
  output logic [3:0] oDIGIT0,
  output logic [3:0] oDIGIT1,
  output logic [3:0] oDIGIT2,
  output logic [3:0] oDIGIT3,
  output logic       oFOUL,
  output logic       oBUSY
);

  localparam int PRE_N  = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W  = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_N - 1);
  localparam int WAIT_W = $clog2(MIN_WAIT_MS + 2048 + 1);

  state_t            r_state, w_next;
  logic [PRE_W-1:0]  r_pre;
  logic              w_tick;
  logic [15:0]       r_lfsr;
  logic              r_resp_d;
  logic              w_resp_rise;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_start_ok;
  logic              w_enter_timed;
  logic [15:0]       w_bcd;

  logic              w_led, w_busy, w_foul;
  logic [15:0]       w_digits;
  logic              r_led, r_busy, r_foul;
  logic [15:0]       r_digits;

  // Edge register runs in every state, so a button already held when WAIT
  // or MEASURE begins is never seen as a fresh press.
  assign w_resp_rise = iRESP && !r_resp_d;
  assign w_tick      = (r_pre == PRE_MAX);
  assign w_start_ok  = iSTART &&
                       (r_state == S_IDLE || r_state == S_DONE || r_state == S_FOUL);
  assign w_enter_timed = (w_next != r_state) &&
                         (w_next == S_WAIT || w_next == S_MEASURE);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_lfsr   <= LFSR_SEED;
      r_resp_d <= 1'b0;
    end else begin
      r_lfsr   <= lfsr_next(r_lfsr);
      r_resp_d <= iRESP;
    end
  end

  // ms prescaler restarts on entry to a timed state so the first ms is full.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)            r_pre <= '0;
    else if (w_enter_timed) r_pre <= '0;
    else if (w_tick)        r_pre <= '0;
    else                    r_pre <= r_pre + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)
      r_wait_cnt <= '0;
    else if (w_start_ok)
      r_wait_cnt <= WAIT_W'(MIN_WAIT_MS) + WAIT_W'(r_lfsr[10:0]);
    else if (r_state == S_WAIT && w_tick && r_wait_cnt != '0)
      r_wait_cnt <= r_wait_cnt - 1'b1;
  end

  // FSM: state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM: next state. A press in WAIT beats a same-cycle expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FOUL: if (iSTART) w_next = S_WAIT;
      S_WAIT: begin
        if (w_resp_rise)
          w_next = S_FOUL;
        else if (w_tick && r_wait_cnt <= WAIT_W'(1))
          w_next = S_MEASURE;
      end
      S_MEASURE: if (w_resp_rise) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs (registered below)
  always_comb begin
    w_led    = (r_state == S_MEASURE);
    w_busy   = (r_state == S_WAIT) || (r_state == S_MEASURE);
    w_foul   = (r_state == S_FOUL);
    w_digits = (r_state == S_FOUL) ? {4{FOUL_CODE}} : w_bcd;
  end

  // The tick on the press cycle still counts; the counter stops once the
  // state has left MEASURE.
  bcd_counter4 u_bcd (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .clr   (w_start_ok),
    .inc   ((r_state == S_MEASURE) && w_tick),
    .bcd   (w_bcd)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_led    <= 1'b0;
      r_busy   <= 1'b0;
      r_foul   <= 1'b0;
      r_digits <= 16'h0000;
    end else begin
      r_led    <= w_led;
      r_busy   <= w_busy;
      r_foul   <= w_foul;
      r_digits <= w_digits;
    end
  end

  assign oLED    = r_led;
  assign oBUSY   = r_busy;
  assign oFOUL   = r_foul;
  assign oDIGIT0 = r_digits[3:0];
  assign oDIGIT1 = r_digits[7:4];
  assign oDIGIT2 = r_digits[11:8];
  assign oDIGIT3 = r_digits[15:12];

endmodule

// File: tb/tb_reaction_ctrl.sv
module tb_reaction_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST_n;
  logic       iSTART;
  logic       iRESP;
  logic       oLED;
  logic [3:0] oDIGIT0, oDIGIT1, oDIGIT2, oDIGIT3;
  logic       oFOUL;
  logic       oBUSY;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  int          exp_w;

  reaction_ctrl #(.CLK_HZ(1000), .MIN_WAIT_MS(4)) u_dut (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iSTART  (iSTART),
    .iRESP   (iRESP),
    .oLED    (oLED),
    .oDIGIT0 (oDIGIT0),
    .oDIGIT1 (oDIGIT1),
    .oDIGIT2 (oDIGIT2),
    .oDIGIT3 (oDIGIT3),
    .oFOUL   (oFOUL),
    .oBUSY   (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference LFSR tracking the one inside the design.
  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) m_lfsr <= 16'hACE1;
    else         m_lfsr <= ref_step(m_lfsr);
  end

  function automatic logic [15:0] digits();
    return {oDIGIT3, oDIGIT2, oDIGIT1, oDIGIT0};
  endfunction

  // Called at a negedge: pulses iSTART for one cycle and records the
  // expected delay load from the LFSR value the design samples.
  task automatic do_start();
    exp_w  = 4 + int'(m_lfsr[10:0]);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic wait_led(output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge iCLK);
      cycles++;
      if (oLED === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge iCLK);
    iRST_n = 1'b0;
    iSTART = 1'b0;
    iRESP  = 1'b0;
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (2) @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; iSTART = 1'b0; iRESP = 1'b0;
    #12;
    n_checks++;
    if ({oLED, oFOUL, oBUSY, digits()} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got led=%b foul=%b busy=%b dig=%h, want all 0",
               oLED, oFOUL, oBUSY, digits());
    end
    n_checks++;
    if (u_dut.r_lfsr !== 16'hACE1) begin
      n_fail++;
      $display("FAIL reset_lfsr: got %h want ace1", u_dut.r_lfsr);
    end
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (3) @(negedge iCLK);
    n_checks++;
    if ({oLED, oFOUL, oBUSY, digits()} !== 19'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got led=%b foul=%b busy=%b dig=%h, want all 0",
               oLED, oFOUL, oBUSY, digits());
    end
  endtask

  task automatic test_normal_run();
    int cyc; bit ok;
    do_start();
    n_checks++;
    if (int'(u_dut.r_wait_cnt) !== exp_w) begin
      n_fail++;
      $display("FAIL wait_load: got %0d want %0d", u_dut.r_wait_cnt, exp_w);
    end
    wait_led(cyc, ok);
    n_checks++;
    if (!ok || cyc != exp_w + 1) begin
      n_fail++;
      $display("FAIL led_delay: got %0d cycles (seen=%b) want %0d", cyc, ok, exp_w + 1);
    end
    n_checks++;
    if (digits() !== 16'h0000 || oBUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL measure_start: got dig=%h busy=%b want 0000 busy=1", digits(), oBUSY);
    end
    repeat (35) @(negedge iCLK);
    iRESP = 1'b1;
    repeat (3) @(negedge iCLK);
    n_checks++;
    if (digits() !== 16'h0037 || oLED !== 1'b0 || oBUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_done: got dig=%h led=%b busy=%b want 0037 0 0",
               digits(), oLED, oBUSY);
    end
    iRESP = 1'b0;
    repeat (6) @(negedge iCLK);
    n_checks++;
    if (digits() !== 16'h0037) begin
      n_fail++;
      $display("FAIL done_hold: got %h want 0037", digits());
    end
  endtask

  task automatic test_foul();
    bit led_seen = 1'b0;
    do_start();
    @(negedge iCLK);
    iRESP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      if (oLED === 1'b1) led_seen = 1'b1;
    end
    n_checks++;
    if (oFOUL !== 1'b1 || digits() !== 16'hFFFF || oBUSY !== 1'b0 || led_seen) begin
      n_fail++;
      $display("FAIL foul: got foul=%b dig=%h busy=%b led_seen=%b want 1 ffff 0 0",
               oFOUL, digits(), oBUSY, led_seen);
    end
    iRESP = 1'b0;
    @(negedge iCLK);
    do_start();
    repeat (2) @(negedge iCLK);
    n_checks++;
    if (digits() !== 16'h0000 || oFOUL !== 1'b0 || oBUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL foul_restart: got dig=%h foul=%b busy=%b want 0000 0 1",
               digits(), oFOUL, oBUSY);
    end
    pulse_reset();
  endtask

  task automatic test_saturation();
    int cyc; bit ok;
    do_start();
    wait_led(cyc, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sat_led_timeout: lamp not lit after %0d cycles", cyc);
    end
    repeat (12000) @(negedge iCLK);
    n_checks++;
    if (digits() !== 16'h9999 || oBUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got dig=%h busy=%b want 9999 1", digits(), oBUSY);
    end
    iRESP = 1'b1;
    repeat (3) @(negedge iCLK);
    n_checks++;
    if (digits() !== 16'h9999 || oBUSY !== 1'b0 || oLED !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_done: got dig=%h busy=%b led=%b want 9999 0 0",
               digits(), oBUSY, oLED);
    end
    iRESP = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic test_edge_rules();
    int cyc; bit ok;
    iRESP = 1'b1;
    @(negedge iCLK);
    do_start();
    wait_led(cyc, ok);
    n_checks++;
    if (!ok || oFOUL !== 1'b0) begin
      n_fail++;
      $display("FAIL held_no_foul: got led_seen=%b foul=%b want 1 0", ok, oFOUL);
    end
    repeat (3) @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (4) @(negedge iCLK);
    n_checks++;
    if (oBUSY !== 1'b1 || oLED !== 1'b1) begin
      n_fail++;
      $display("FAIL held_no_done: got busy=%b led=%b want 1 1", oBUSY, oLED);
    end
    iRESP = 1'b0;
    repeat (5) @(negedge iCLK);
    iRESP = 1'b1;
    repeat (3) @(negedge iCLK);
    n_checks++;
    if (digits() !== 16'h0015 || oBUSY !== 1'b0 || oFOUL !== 1'b0) begin
      n_fail++;
      $display("FAIL repress_done: got dig=%h busy=%b foul=%b want 0015 0 0",
               digits(), oBUSY, oFOUL);
    end
    iRESP = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic test_mid_run_reset();
    int cyc; bit ok;
    do_start();
    wait_led(cyc, ok);
    repeat (5) @(negedge iCLK);
    #2 iRST_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || oLED !== 1'b0 || digits() !== 16'h0000 || oBUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: got led=%b dig=%h busy=%b (lit=%b) want 0 0000 0 1",
               oLED, digits(), oBUSY, ok);
    end
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (5) @(negedge iCLK);
    n_checks++;
    if (oBUSY !== 1'b0 || oLED !== 1'b0) begin
      n_fail++;
      $display("FAIL stay_idle: got busy=%b led=%b want 0 0", oBUSY, oLED);
    end
    do_start();
    @(negedge iCLK);
    n_checks++;
    if (oBUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_reset: got busy=%b want 1", oBUSY);
    end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_foul();
    test_saturation();
    test_edge_rules();
    test_mid_run_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
